aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 192 +++++++++++++++++++
 tb/tb_aes_iter_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryption core: one round per clock, round keys expanded on the fly.
// Optional abort input is compiled in when AES_ITER_ABORT_EN is defined.
module aes_iter_core #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
`ifdef AES_ITER_ABORT_EN
  input  logic                abort,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        cipher_text,
  output logic                busy
);
  localparam int unsigned NK    = KEY_BITS / 32;
  localparam int unsigned NR    = NK + 6;
  localparam int unsigned RND_W = 4;
  localparam int unsigned EXT_W = NK + 4;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_key_bits_check
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [RND_W-1:0]      rnd;
  logic [127:0]          st;
  logic [KEY_BITS-1:0]   win;
  logic                  kill;
  logic [KEY_BITS+127:0] ks;
  logic [127:0]          rk;
  logic [127:0]          round_out;
  logic [KEY_BITS-1:0]   win_nxt;

`ifdef AES_ITER_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    for (int unsigned b = 0; b < 16; b++) sb[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    for (int unsigned c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    return (last ? sr : mc) ^ k;
  endfunction

  // Window holds w[4r-4 .. 4r+Nk-5]; four new words extend it, round key r is words 4..7
  function automatic logic [KEY_BITS+127:0] key_step(input logic [KEY_BITS-1:0] w,
                                                     input logic [RND_W-1:0] r);
    logic [31:0]         ext [EXT_W];
    logic [31:0]         t;
    logic [KEY_BITS-1:0] nw;
    int unsigned         i;
    for (int unsigned k = 0; k < NK; k++) ext[k] = w[KEY_BITS-1-32*k -: 32];
    for (int unsigned j = 0; j < 4; j++) begin
      i = 4 * 32'(r) + NK - 4 + j;
      t = ext[NK+j-1];
      if (i % NK == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(4'(i / NK)), 24'h000000};
      else if (NK == 8 && i % NK == 4) t = sub_word(t);
      ext[NK+j] = ext[j] ^ t;
    end
    for (int unsigned k = 0; k < NK; k++) nw[KEY_BITS-1-32*k -: 32] = ext[k+4];
    return {ext[4], ext[5], ext[6], ext[7], nw};
  endfunction

  assign ks        = key_step(win, rnd);
  assign rk        = ks[KEY_BITS+127 -: 128];
  assign win_nxt   = ks[KEY_BITS-1:0];
  assign round_out = aes_round(st, rk, rnd == RND_W'(NR));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rnd         <= '0;
      st          <= '0;
      win         <= '0;
      cipher_text <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else if (kill) begin
      state     <= IDLE;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= plaintext ^ key[KEY_BITS-1 -: 128];
            win      <= key;
            rnd      <= RND_W'(1);
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          st  <= round_out;
          win <= win_nxt;
          if (rnd == RND_W'(NR)) begin
            state       <= DONE;
            cipher_text <= round_out;
            out_valid   <= 1'b1;
            rnd         <= '0;
          end else begin
            rnd <= rnd + RND_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: one instance per key size, known-answer vectors
// plus back-pressure, input disturbance, mid-run reset and (with AES_ITER_ABORT_EN) abort.
module tb_aes_iter_core;
  logic         clk = 1'b0;
  logic         reset;
`ifdef AES_ITER_ABORT_EN
  logic         abort;
`endif
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext;
  logic [255:0] key_src;
  logic [127:0] ct [3];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .reset(reset),
`ifdef AES_ITER_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .plaintext(plaintext),
    .key(key_src[255:128]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .cipher_text(ct[0]), .busy(busy[0]));

  aes_iter_core #(.KEY_BITS(192)) dut192 (
    .clk(clk), .reset(reset),
`ifdef AES_ITER_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .plaintext(plaintext),
    .key(key_src[255:64]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .cipher_text(ct[1]), .busy(busy[1]));

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .reset(reset),
`ifdef AES_ITER_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .plaintext(plaintext),
    .key(key_src), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .cipher_text(ct[2]), .busy(busy[2]));

  typedef struct {
    int           sel;
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] exp;
    string        name;
  } vec_t;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input int sel, input logic [127:0] pt, input logic [255:0] k);
    for (int w = 0; w < 40 && in_ready[sel] !== 1'b1; w++) @(negedge clk);
    check("ready_before_accept", 256'(in_ready[sel]), 256'(1));
    plaintext     = pt;
    key_src       = k;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    check("busy_after_accept", 256'(busy[sel]), 256'(1));
    check("in_ready_after_accept", 256'(in_ready[sel]), 256'(0));
  endtask

  task automatic wait_result(input int sel, input int nr, input logic [127:0] exp,
                             input string name);
    int lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid[sel] === 1'b1) lat = k;
    end
    check({name, "_latency"}, 256'(lat), 256'(nr));
    check({name, "_cipher"}, 256'(ct[sel]), 256'(exp));
  endtask

  task automatic release_out(input int sel, input logic [127:0] exp);
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check("out_valid_after_release", 256'(out_valid[sel]), 256'(0));
    check("in_ready_after_release", 256'(in_ready[sel]), 256'(1));
    check("cipher_held_in_idle", 256'(ct[sel]), 256'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   seen;
    vecs[0] = '{0, PT_C1, KEY_C1, CT_C1, "c1_128"};
    vecs[1] = '{1, PT_C1, KEY_C1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "c1_192"};
    vecs[2] = '{2, PT_C1, KEY_C1, 128'h8ea2b7ca516745bfeafc49904b496089, "c1_256"};
    vecs[3] = '{0, 128'h0, 256'h0, CT_Z, "zero_128"};
    vecs[4] = '{1, 128'h0, 256'h0, 128'haae06992acbf52a3e8f4a96ec9300bd7, "zero_192"};
    vecs[5] = '{2, 128'h0, 256'h0, 128'hdc95c078a2408989ad48a21492842087, "zero_256"};
    vecs[6] = '{0, PT_B, KEY_B, CT_B, "fips_b_128"};

    reset     = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    plaintext = '0;
    key_src   = '0;
`ifdef AES_ITER_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset_in_ready", 256'(in_ready[s]), 256'(1));
      check("reset_out_valid", 256'(out_valid[s]), 256'(0));
      check("reset_busy", 256'(busy[s]), 256'(0));
      check("reset_cipher", 256'(ct[s]), 256'(0));
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].sel, vecs[i].pt, vecs[i].key);
      wait_result(vecs[i].sel, 10 + 2 * vecs[i].sel, vecs[i].exp, vecs[i].name);
      release_out(vecs[i].sel, vecs[i].exp);
    end

    // Back-pressure: result must hold while out_ready stays low
    accept(0, PT_B, KEY_B);
    wait_result(0, 10, CT_B, "bp");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_hold", 256'({out_valid[0], in_ready[0], ct[0]}), 256'({1'b1, 1'b0, CT_B}));
    end
    release_out(0, CT_B);

    // Disturbance: random inputs and in_valid held high while running
    accept(0, PT_C1, KEY_C1);
    in_valid[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key_src   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (c == 5) out_ready[0] = 1'b1;
      @(negedge clk);
    end
    plaintext = 128'h0;
    key_src   = 256'h0;
    @(negedge clk);
    check("dist_out_valid", 256'(out_valid[0]), 256'(1));
    check("dist_cipher", 256'(ct[0]), 256'(CT_C1));
    @(negedge clk);
    check("dist_not_accepted_in_done", 256'({in_ready[0], out_valid[0]}), 256'(2'b10));
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("dist_second_accepted", 256'({busy[0], in_ready[0]}), 256'(2'b10));
    wait_result(0, 10, CT_Z, "dist_second");
    release_out(0, CT_Z);

    // Reset during round 5 discards the block
    accept(0, PT_C1, KEY_C1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_state", 256'({in_ready[0], out_valid[0], busy[0]}), 256'(3'b100));
    check("rst_mid_cipher", 256'(ct[0]), 256'(0));
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen = 1;
    end
    check("rst_mid_no_result", 256'(seen), 256'(0));
    accept(0, PT_B, KEY_B);
    wait_result(0, 10, CT_B, "after_reset");
    release_out(0, CT_B);

`ifdef AES_ITER_ABORT_EN
    // Abort at round 3 wins over a simultaneous acceptance
    accept(0, PT_C1, KEY_C1);
    @(negedge clk);
    @(negedge clk);
    abort       = 1'b1;
    in_valid[0] = 1'b1;
    plaintext   = 128'h0;
    key_src     = 256'h0;
    @(negedge clk);
    abort       = 1'b0;
    in_valid[0] = 1'b0;
    check("abort_state", 256'({in_ready[0], out_valid[0], busy[0]}), 256'(3'b100));
    check("abort_cipher_kept", 256'(ct[0]), 256'(CT_B));
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1 || busy[0] === 1'b1) seen = 1;
    end
    check("abort_no_result", 256'(seen), 256'(0));
    accept(0, PT_C1, KEY_C1);
    wait_result(0, 10, CT_C1, "after_abort");
    release_out(0, CT_C1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
